// File: rtl/exc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exc_pkg
// Shared types and constants for the exception/interrupt sequencer.
//   state_e  : sequencer states (RUN -> ENTER -> HANDLER -> LEAVE -> RUN)
//   EXC_*    : CP0 cause codes written to exc_code_o
// -----------------------------------------------------------------------------
package exc_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_LEAVE   = 2'd3
    } state_e;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BRK = 5'd9;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    // Synchronous-exception cause in priority order: ri > ov > sys > brk.
    // Falls through to the interrupt code when no synchronous flag is set.
    function automatic logic [4:0] sync_cause(input logic ri, input logic ov,
                                              input logic sys, input logic brk);
        logic [4:0] code;
        code = EXC_INT;
        if (ri)       code = EXC_RI;
        else if (ov)  code = EXC_OV;
        else if (sys) code = EXC_SYS;
        else if (brk) code = EXC_BRK;
        return code;
    endfunction

endpackage

// File: rtl/exc_ctrl_int_latch.sv
// -----------------------------------------------------------------------------
// int_latch
// Rising-edge detector, pending register and lowest-index priority encoder for
// the external interrupt lines.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   int_i        : raw interrupt request levels
//   mask_i       : 1 = line enabled (gates both latching and selection)
//   clr_i        : one-hot clear of the line being taken this cycle
//   pending_o    : latched pending lines
//   valid_o      : some pending line is also enabled
//   idx_o        : lowest enabled pending index (valid only with valid_o)
// -----------------------------------------------------------------------------
module int_latch #(
    parameter  int NUM_INT = 6,
    localparam int IDX_W   = (NUM_INT > 1) ? $clog2(NUM_INT) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_INT-1:0] int_i,
    input  logic [NUM_INT-1:0] mask_i,
    input  logic [NUM_INT-1:0] clr_i,
    output logic [NUM_INT-1:0] pending_o,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [NUM_INT-1:0] r_int_prev;
    logic [NUM_INT-1:0] r_pending;
    logic [NUM_INT-1:0] w_rise;
    logic [NUM_INT-1:0] w_req;
    logic [IDX_W-1:0]   w_idx;

    // An edge on a masked line is dropped, not deferred.
    assign w_rise = int_i & ~r_int_prev & mask_i;
    assign w_req  = r_pending & mask_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_prev <= '0;
            r_pending  <= '0;
        end else begin
            r_int_prev <= int_i;
            // A fresh edge on the line being cleared re-arms it.
            r_pending  <= (r_pending & ~clr_i) | w_rise;
        end
    end

    // Scan downward so the lowest set index is the final assignment.
    always_comb begin
        w_idx = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (w_req[i]) w_idx = IDX_W'(i);
        end
    end

    assign pending_o = r_pending;
    assign valid_o   = |w_req;
    assign idx_o     = w_idx;

endmodule

// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl
// Exception/interrupt sequencer in front of CP0. Picks the highest-priority
// synchronous exception or enabled interrupt, then walks RUN -> ENTER ->
// HANDLER; an eret in HANDLER walks LEAVE -> RUN.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   pc_i                : PC of the instruction in EX (captured as EPC)
//   int_i, int_mask_i   : interrupt levels and enables
//   ex_ri/ov/sys/brk_i  : synchronous exception flags for pc_i
//   eret_i              : eret in EX
//   handler_pc_i, epc_i : redirect targets for entry / return
//   exl_set_o/clear_o   : one-cycle CP0 EXL strobes (ENTER / LEAVE)
//   epc_pc_o            : PC to store into EPC
//   redirect_o/_pc_o    : one-cycle PC-mux override and target
//   flush_o             : one-cycle IF/ID/EX flush
//   exc_code_o          : cause code of the last exception taken
//   in_handler_o        : shadow of CP0 EXL
//   int_pending_o       : latched pending interrupts
//   err_o               : sticky protocol error (eret in RUN, exception in HANDLER)
//   dbg_state_o         : current sequencer state
// -----------------------------------------------------------------------------
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int NUM_INT = 6,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [NUM_INT-1:0] int_i,
    input  logic [NUM_INT-1:0] int_mask_i,
    input  logic               ex_ri_i,
    input  logic               ex_ov_i,
    input  logic               ex_sys_i,
    input  logic               ex_brk_i,
    input  logic               eret_i,
    input  logic [PC_W-1:0]    handler_pc_i,
    input  logic [PC_W-1:0]    epc_i,
    output logic               exl_set_o,
    output logic               exl_clear_o,
    output logic [PC_W-1:0]    epc_pc_o,
    output logic               redirect_o,
    output logic [PC_W-1:0]    redirect_pc_o,
    output logic               flush_o,
    output logic [4:0]         exc_code_o,
    output logic               in_handler_o,
    output logic [NUM_INT-1:0] int_pending_o,
    output logic               err_o,
    output logic [1:0]         dbg_state_o
);

    localparam int IDX_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

    state_e             r_state;
    logic               r_exl_set;
    logic               r_exl_clear;
    logic               r_redirect;
    logic               r_flush;
    logic [PC_W-1:0]    r_epc_pc;
    logic [4:0]         r_exc_code;
    logic               r_in_handler;
    logic               r_err;

    logic               w_sync_req;
    logic               w_int_valid;
    logic [IDX_W-1:0]   w_int_idx;
    logic               w_take_int;
    logic [NUM_INT-1:0] w_int_clr;
    logic [4:0]         w_cause;
    logic [PC_W-1:0]    w_redirect_pc;

    assign w_sync_req = ex_ri_i | ex_ov_i | ex_sys_i | ex_brk_i;
    assign w_cause    = sync_cause(ex_ri_i, ex_ov_i, ex_sys_i, ex_brk_i);

    // An interrupt is taken only in RUN and only when no synchronous
    // exception outranks it; only then is its pending bit consumed.
    assign w_take_int = (r_state == ST_RUN) && !w_sync_req && w_int_valid;
    assign w_int_clr  = w_take_int ? (NUM_INT'(1) << w_int_idx) : '0;

    int_latch #(
        .NUM_INT (NUM_INT)
    ) u_int_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .int_i     (int_i),
        .mask_i    (int_mask_i),
        .clr_i     (w_int_clr),
        .pending_o (int_pending_o),
        .valid_o   (w_int_valid),
        .idx_o     (w_int_idx)
    );

    // Single FSM block; strobes are registered so they assert exactly in
    // the ENTER / LEAVE cycle and drop at once on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_exl_set    <= 1'b0;
            r_exl_clear  <= 1'b0;
            r_redirect   <= 1'b0;
            r_flush      <= 1'b0;
            r_epc_pc     <= '0;
            r_exc_code   <= EXC_INT;
            r_in_handler <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_exl_set   <= 1'b0;
            r_exl_clear <= 1'b0;
            r_redirect  <= 1'b0;
            r_flush     <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_sync_req || w_int_valid) begin
                        r_epc_pc   <= pc_i;
                        r_exc_code <= w_cause;
                        r_exl_set  <= 1'b1;
                        r_redirect <= 1'b1;
                        r_flush    <= 1'b1;
                        r_state    <= ST_ENTER;
                    end
                    // eret outside a handler has nothing to return from.
                    if (eret_i) r_err <= 1'b1;
                end
                ST_ENTER: begin
                    r_in_handler <= 1'b1;
                    r_state      <= ST_HANDLER;
                end
                ST_HANDLER: begin
                    // No nesting: a synchronous exception here is a fault.
                    if (w_sync_req) r_err <= 1'b1;
                    if (eret_i) begin
                        r_exl_clear <= 1'b1;
                        r_redirect  <= 1'b1;
                        r_flush     <= 1'b1;
                        r_state     <= ST_LEAVE;
                    end
                end
                ST_LEAVE: begin
                    r_in_handler <= 1'b0;
                    r_state      <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Target is decoded from state; epc_i must be read during LEAVE,
    // before CP0 clears EPC on the closing edge.
    always_comb begin
        w_redirect_pc = '0;
        case (r_state)
            ST_ENTER: w_redirect_pc = handler_pc_i;
            ST_LEAVE: w_redirect_pc = epc_i;
            default:  w_redirect_pc = '0;
        endcase
    end

    assign exl_set_o     = r_exl_set;
    assign exl_clear_o   = r_exl_clear;
    assign redirect_o    = r_redirect;
    assign flush_o       = r_flush;
    assign redirect_pc_o = w_redirect_pc;
    assign epc_pc_o      = r_epc_pc;
    assign exc_code_o    = r_exc_code;
    assign in_handler_o  = r_in_handler;
    assign err_o         = r_err;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

  localparam int NUM_INT = 6;
  localparam int PC_W    = 32;

  logic               clk;
  logic               rst_n;
  logic [PC_W-1:0]    pc_i;
  logic [NUM_INT-1:0] int_i;
  logic [NUM_INT-1:0] int_mask_i;
  logic               ex_ri_i, ex_ov_i, ex_sys_i, ex_brk_i, eret_i;
  logic [PC_W-1:0]    handler_pc_i, epc_i;
  logic               exl_set_o, exl_clear_o, redirect_o, flush_o;
  logic [PC_W-1:0]    epc_pc_o, redirect_pc_o;
  logic [4:0]         exc_code_o;
  logic               in_handler_o, err_o;
  logic [NUM_INT-1:0] int_pending_o;
  logic [1:0]         dbg_state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  exc_ctrl #(.NUM_INT(NUM_INT), .PC_W(PC_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_i          (pc_i),
    .int_i         (int_i),
    .int_mask_i    (int_mask_i),
    .ex_ri_i       (ex_ri_i),
    .ex_ov_i       (ex_ov_i),
    .ex_sys_i      (ex_sys_i),
    .ex_brk_i      (ex_brk_i),
    .eret_i        (eret_i),
    .handler_pc_i  (handler_pc_i),
    .epc_i         (epc_i),
    .exl_set_o     (exl_set_o),
    .exl_clear_o   (exl_clear_o),
    .epc_pc_o      (epc_pc_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .flush_o       (flush_o),
    .exc_code_o    (exc_code_o),
    .in_handler_o  (in_handler_o),
    .int_pending_o (int_pending_o),
    .err_o         (err_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    pc_i         = '0;
    int_i        = '0;
    int_mask_i   = '0;
    ex_ri_i      = 1'b0;
    ex_ov_i      = 1'b0;
    ex_sys_i     = 1'b0;
    ex_brk_i     = 1'b0;
    eret_i       = 1'b0;
    handler_pc_i = 32'h0000_00F0;
    epc_i        = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Strobe bundle order: {exl_set, exl_clear, redirect, flush}

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    repeat (10) tick();
    n_cmp++;
    if ({exl_set_o, exl_clear_o, redirect_o, flush_o} !== 4'b0000) begin
      $display("FAIL reset_strobes: got %b want 0000", {exl_set_o, exl_clear_o, redirect_o, flush_o});
      n_fail++;
    end
    n_cmp++;
    if ({epc_pc_o, redirect_pc_o} !== 64'd0) begin
      $display("FAIL reset_pcs: epc %h redir %h want 0", epc_pc_o, redirect_pc_o);
      n_fail++;
    end
    n_cmp++;
    if ({exc_code_o, in_handler_o, int_pending_o, err_o} !== 13'd0) begin
      $display("FAIL reset_misc: code %0d inh %b pend %b err %b want 0", exc_code_o, in_handler_o, int_pending_o, err_o);
      n_fail++;
    end
    n_cmp++;
    if (dbg_state_o !== 2'd0) begin
      $display("FAIL reset_state: got %0d want 0", dbg_state_o);
      n_fail++;
    end
  endtask

  task automatic test_sys_entry();
    pc_i     = 32'h0000_0040;
    ex_sys_i = 1'b1;
    tick();
    ex_sys_i = 1'b0;
    n_cmp++;
    if ({exl_set_o, exl_clear_o, redirect_o, flush_o} !== 4'b1011) begin
      $display("FAIL enter_strobes: got %b want 1011", {exl_set_o, exl_clear_o, redirect_o, flush_o});
      n_fail++;
    end
    n_cmp++;
    if (redirect_pc_o !== 32'h0000_00F0) begin
      $display("FAIL enter_redir_pc: got %h want 000000f0", redirect_pc_o);
      n_fail++;
    end
    n_cmp++;
    if (epc_pc_o !== 32'h0000_0040) begin
      $display("FAIL enter_epc: got %h want 00000040", epc_pc_o);
      n_fail++;
    end
    n_cmp++;
    if (exc_code_o !== 5'd8) begin
      $display("FAIL enter_code_sys: got %0d want 8", exc_code_o);
      n_fail++;
    end
    n_cmp++;
    if (in_handler_o !== 1'b0) begin
      $display("FAIL enter_inh: got %b want 0", in_handler_o);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({in_handler_o, exl_set_o, dbg_state_o} !== 4'b1010) begin
      $display("FAIL handler_entry: inh %b set %b state %0d want 1 0 2", in_handler_o, exl_set_o, dbg_state_o);
      n_fail++;
    end
  endtask

  task automatic test_eret();
    epc_i  = 32'h0000_0040;
    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;
    n_cmp++;
    if ({exl_set_o, exl_clear_o, redirect_o, flush_o} !== 4'b0111) begin
      $display("FAIL leave_strobes: got %b want 0111", {exl_set_o, exl_clear_o, redirect_o, flush_o});
      n_fail++;
    end
    n_cmp++;
    if (redirect_pc_o !== 32'h0000_0040) begin
      $display("FAIL leave_redir_pc: got %h want 00000040", redirect_pc_o);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({in_handler_o, exl_clear_o, dbg_state_o} !== 4'b0000) begin
      $display("FAIL leave_exit: inh %b clr %b state %0d want 0 0 0", in_handler_o, exl_clear_o, dbg_state_o);
      n_fail++;
    end
    n_cmp++;
    if (err_o !== 1'b0) begin
      $display("FAIL leave_err: got %b want 0", err_o);
      n_fail++;
    end
  endtask

  task automatic test_priority();
    int_mask_i = 6'h3F;
    pc_i       = 32'h0000_0100;
    ex_ov_i    = 1'b1;
    ex_brk_i   = 1'b1;
    int_i      = 6'b000100;
    tick();
    ex_ov_i  = 1'b0;
    ex_brk_i = 1'b0;
    n_cmp++;
    if (exc_code_o !== 5'd12 || epc_pc_o !== 32'h0000_0100) begin
      $display("FAIL prio_ov: code %0d epc %h want 12 00000100", exc_code_o, epc_pc_o);
      n_fail++;
    end
    n_cmp++;
    if (int_pending_o !== 6'b000100) begin
      $display("FAIL prio_pend_enter: got %b want 000100", int_pending_o);
      n_fail++;
    end
    tick();
    epc_i  = 32'h0000_0100;
    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;
    n_cmp++;
    if (int_pending_o !== 6'b000100 || exl_clear_o !== 1'b1) begin
      $display("FAIL prio_pend_leave: pend %b clr %b want 000100 1", int_pending_o, exl_clear_o);
      n_fail++;
    end
    pc_i = 32'h0000_0200;
    tick();
    n_cmp++;
    if (dbg_state_o !== 2'd0 || exl_set_o !== 1'b0) begin
      $display("FAIL prio_run_gap: state %0d set %b want 0 0", dbg_state_o, exl_set_o);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({exl_set_o, exc_code_o} !== 6'b1_00000 || epc_pc_o !== 32'h0000_0200) begin
      $display("FAIL int2_entry: set %b code %0d epc %h want 1 0 00000200", exl_set_o, exc_code_o, epc_pc_o);
      n_fail++;
    end
    n_cmp++;
    if (int_pending_o !== 6'b000000) begin
      $display("FAIL int2_pend_clr: got %b want 000000", int_pending_o);
      n_fail++;
    end
    tick();
    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;
    tick();
  endtask

  task automatic test_mask();
    int_mask_i = 6'b110111;
    int_i      = 6'b001000;
    tick();
    n_cmp++;
    if (int_pending_o !== 6'b000000) begin
      $display("FAIL mask_pend3: got %b want 000000", int_pending_o);
      n_fail++;
    end
    tick();
    n_cmp++;
    if (dbg_state_o !== 2'd0 || exl_set_o !== 1'b0) begin
      $display("FAIL mask_no_entry: state %0d set %b want 0 0", dbg_state_o, exl_set_o);
      n_fail++;
    end
    pc_i     = 32'h0000_0300;
    ex_brk_i = 1'b1;
    tick();
    ex_brk_i = 1'b0;
    n_cmp++;
    if (exc_code_o !== 5'd9) begin
      $display("FAIL brk_code: got %0d want 9", exc_code_o);
      n_fail++;
    end
    tick();
    int_i = 6'b011010;
    tick();
    n_cmp++;
    if (int_pending_o !== 6'b010010 || dbg_state_o !== 2'd2) begin
      $display("FAIL hnd_latch: pend %b state %0d want 010010 2", int_pending_o, dbg_state_o);
      n_fail++;
    end
    epc_i  = 32'h0000_0300;
    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;
    pc_i   = 32'h0000_0400;
    tick();
    tick();
    n_cmp++;
    if ({exl_set_o, exc_code_o} !== 6'b1_00000 || epc_pc_o !== 32'h0000_0400) begin
      $display("FAIL int1_entry: set %b code %0d epc %h want 1 0 00000400", exl_set_o, exc_code_o, epc_pc_o);
      n_fail++;
    end
    n_cmp++;
    if (int_pending_o !== 6'b010000) begin
      $display("FAIL int1_lowest: pend %b want 010000", int_pending_o);
      n_fail++;
    end
    tick();
    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (exl_set_o !== 1'b1 || int_pending_o !== 6'b000000) begin
      $display("FAIL int4_entry: set %b pend %b want 1 000000", exl_set_o, int_pending_o);
      n_fail++;
    end
    tick();
    int_i  = '0;
    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;
    tick();
  endtask

  task automatic test_errors();
    n_cmp++;
    if (err_o !== 1'b0 || dbg_state_o !== 2'd0) begin
      $display("FAIL err_pre: err %b state %0d want 0 0", err_o, dbg_state_o);
      n_fail++;
    end
    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;
    n_cmp++;
    if (err_o !== 1'b1) begin
      $display("FAIL eret_run_err: got %b want 1", err_o);
      n_fail++;
    end
    n_cmp++;
    if ({exl_set_o, exl_clear_o, redirect_o, flush_o} !== 4'b0000 || dbg_state_o !== 2'd0) begin
      $display("FAIL eret_run_quiet: strobes %b state %0d want 0000 0", {exl_set_o, exl_clear_o, redirect_o, flush_o}, dbg_state_o);
      n_fail++;
    end

    do_reset();
    pc_i     = 32'h0000_0500;
    ex_sys_i = 1'b1;
    tick();
    ex_sys_i = 1'b0;
    tick();
    ex_ri_i = 1'b1;
    tick();
    ex_ri_i = 1'b0;
    n_cmp++;
    if (err_o !== 1'b1 || exl_set_o !== 1'b0) begin
      $display("FAIL ri_hnd: err %b set %b want 1 0", err_o, exl_set_o);
      n_fail++;
    end
    n_cmp++;
    if (dbg_state_o !== 2'd2 || exc_code_o !== 5'd8) begin
      $display("FAIL ri_hnd_hold: state %0d code %0d want 2 8", dbg_state_o, exc_code_o);
      n_fail++;
    end

    do_reset();
    pc_i     = 32'h0000_0600;
    ex_sys_i = 1'b1;
    tick();
    ex_sys_i = 1'b0;
    n_cmp++;
    if (exl_set_o !== 1'b1) begin
      $display("FAIL rst_pre_enter: set %b want 1", exl_set_o);
      n_fail++;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({exl_set_o, exl_clear_o, redirect_o, flush_o} !== 4'b0000 || dbg_state_o !== 2'd0) begin
      $display("FAIL rst_mid_strobes: strobes %b state %0d want 0000 0", {exl_set_o, exl_clear_o, redirect_o, flush_o}, dbg_state_o);
      n_fail++;
    end
    n_cmp++;
    if ({epc_pc_o, redirect_pc_o} !== 64'd0 || {exc_code_o, in_handler_o, int_pending_o, err_o} !== 13'd0) begin
      $display("FAIL rst_mid_outs: epc %h redir %h code %0d inh %b err %b want 0", epc_pc_o, redirect_pc_o, exc_code_o, in_handler_o, err_o);
      n_fail++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({exl_set_o, exl_clear_o, redirect_o, flush_o} !== 4'b0000 || dbg_state_o !== 2'd0) begin
        $display("FAIL rst_after_%0d: strobes %b state %0d want 0000 0", i, {exl_set_o, exl_clear_o, redirect_o, flush_o}, dbg_state_o);
        n_fail++;
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_sys_entry();
    test_eret();
    test_priority();
    test_mask();
    test_errors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception/interrupt sequencer in front of CP0. Prioritises synchronous exceptions and masked external interrupts, then drives the CP0 EXLSet/EXLClear strobes and the PC to be saved as EPC. Also drives the fetch-stage redirect and the pipeline flush for both exception entry and eret.
Sits between the ID/EX exception flags, the external interrupt pins, CP0 and the PC mux.

Parameters:
NUM_INT, 6, number of external interrupt lines
PC_W, 32, program-counter width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
pc_i  in  PC_W  PC of the instruction currently in EX
int_i  in  NUM_INT  external interrupt request levels
int_mask_i  in  NUM_INT  1 = interrupt line enabled
ex_ri_i  in  1  reserved-instruction flag for pc_i
ex_ov_i  in  1  arithmetic-overflow flag for pc_i
ex_sys_i  in  1  syscall flag for pc_i
ex_brk_i  in  1  break flag for pc_i
eret_i  in  1  eret in EX
handler_pc_i  in  PC_W  exception entry address from CP0
epc_i  in  PC_W  EPC value from CP0
exl_set_o  out  1  one-cycle strobe to CP0 EXLSet
exl_clear_o  out  1  one-cycle strobe to CP0 EXLClear
epc_pc_o  out  PC_W  PC to store in EPC; connects to CP0 PC input
redirect_o  out  1  one-cycle PC-mux override
redirect_pc_o  out  PC_W  override target
flush_o  out  1  one-cycle flush of IF/ID/EX
exc_code_o  out  5  cause code of the last exception taken
in_handler_o  out  1  shadow of CP0 EXL
int_pending_o  out  NUM_INT  latched pending interrupts
err_o  out  1  sticky protocol error

Behaviour:
Reset (async, rst_n=0)
- State goes to RUN.
- All strobes are 0.
- epc_pc_o, redirect_pc_o, exc_code_o, int_pending_o and err_o are all 0.
- in_handler_o is 0.
- Reset mid-sequence abandons the sequence; no strobe is emitted afterwards.

Interrupt latching
- int_pending[i] is set on a rising edge of int_i[i] (previous sample kept in a register).
- It stays set until that line is taken.
- It is never set while the line is masked at the edge.

Cause codes and priority (highest first)
- ri = 10, ov = 12, sys = 8, brk = 9.
- Interrupt = 0, only if (int_pending & int_mask_i) != 0.
- Among interrupts, the lowest index wins.

State RUN
- Any request in cycle N:
  - registers pc_i into epc_pc_o;
  - registers the cause into exc_code_o;
  - for an interrupt, clears that line's pending bit;
  - moves to ENTER.
- eret_i in RUN:
  - ignored;
  - sets err_o.
- An exception and eret in the same cycle: the exception wins and err_o is set.

State ENTER (cycle N+1, exactly one cycle)
- exl_set_o = 1, flush_o = 1, redirect_o = 1, redirect_pc_o = handler_pc_i.
- epc_pc_o is stable this cycle.
- Next state is HANDLER; in_handler_o becomes 1.

State HANDLER
- Interrupts keep latching but are not taken.
- Synchronous exception flags are ignored and set err_o (no nesting).
- eret_i moves to LEAVE.

State LEAVE (exactly one cycle)
- exl_clear_o = 1, flush_o = 1, redirect_o = 1, redirect_pc_o = epc_i.
- epc_i is sampled in this cycle, before CP0 clears EPC on the edge.
- Next state is RUN; in_handler_o becomes 0.
- A pending unmasked interrupt may be taken starting in the first RUN cycle (entry at +1).

Other rules
- err_o is cleared only by reset.
- Outputs are registered or decoded from state only; there are no combinational paths from the *_i flags to the strobes.

Decomposition:
- Package exc_pkg:
  - state enum RUN/ENTER/HANDLER/LEAVE;
  - EXC_INT = 5'd0, EXC_SYS = 5'd8, EXC_BRK = 5'd9, EXC_RI = 5'd10, EXC_OV = 5'd12.
- Sub-module int_latch: edge detect plus pending register plus lowest-index priority encoder.
  - Parameterised by NUM_INT.
  - Outputs a valid bit and an index.
  - Takes a clear-one-hot input.
- The FSM and cause priority stay in exc_ctrl.

Test Plan:
1. Reset then idle 10 cycles.
   - All outputs are 0; state is RUN.
2. ex_sys_i=1 with pc_i=0x0000_0040 in cycle N, handler_pc_i=0xF0.
   - In N+1: exl_set_o=flush_o=redirect_o=1, redirect_pc_o=0xF0, epc_pc_o=0x40, exc_code_o=8.
   - From N+2: in_handler_o=1.
3. While in HANDLER, eret_i=1 with epc_i=0x40.
   - Next cycle: exl_clear_o=1, redirect_pc_o=0x40, flush_o=1.
   - Then in_handler_o=0.
4. ex_ov_i and ex_brk_i together with an unmasked int_i[2] edge.
   - exc_code_o=12.
   - int_pending_o[2] stays 1.
   - After eret, the interrupt enters two cycles after LEAVE with exc_code_o=0, and pending[2] clears.
5. Edge on int_i[3] while int_mask_i[3]=0.
   - int_pending_o[3]=0 and no entry.
   - An edge on int_i[1] with the mask set enters, and the lowest index wins over pending[4].
6. Error and reset cases:
   - eret_i in RUN: err_o=1 and no strobes.
   - ex_ri_i in HANDLER: err_o=1 and no exl_set_o.
   - rst_n=0 asserted during ENTER: strobes drop immediately and all outputs return to 0.
